// File: rtl/tri_bus_pkg.sv
// Shared types and helpers for the tri-state bus receive path.
package tri_bus_pkg;

    typedef logic [7:0] bus_t;

    typedef struct packed {
        logic float_err;
        logic ovf_err;
    } err_t;

    // Pointer width for a FIFO of the given depth; never narrower than one bit.
    function automatic int fifo_aw(input int depth);
        return ($clog2(depth) > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/tri_bus_fifo.sv
// Circular buffer behind the bus listener. The head word, valid, full, empty
// and count are all registered, so the consumer side sees no combinational path.
module tri_bus_fifo
    import tri_bus_pkg::*;
#(
    parameter type T     = bus_t,
    parameter int  DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic                    pop,
    input  T                        wdata,
    output T                        head,
    output logic                    valid,
    output logic                    full,
    output logic                    empty,
    output logic [fifo_aw(DEPTH):0] count
);
    localparam int AW = fifo_aw(DEPTH);
    localparam int CW = AW + 1;

    T              mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [AW-1:0] wr_ptr_nxt_s;
    logic [AW-1:0] rd_ptr_nxt_s;
    logic [CW-1:0] count_r;
    logic [CW-1:0] count_nxt_s;
    T              head_r;
    T              head_nxt_s;
    logic          valid_r;
    logic          full_r;
    logic          empty_r;

    // Next pointers, occupancy and the word that will sit at the head after this edge.
    always_comb begin
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        count_nxt_s  = count_r;
        head_nxt_s   = head_r;

        if (push) begin
            wr_ptr_nxt_s = wr_ptr_r + AW'(1);
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end

        if (pop) begin
            rd_ptr_nxt_s = rd_ptr_r + AW'(1);
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end

        case ({push, pop})
            2'b10:   count_nxt_s = count_r + CW'(1);
            2'b01:   count_nxt_s = count_r - CW'(1);
            default: count_nxt_s = count_r;
        endcase

        // A word written this edge into the next head slot is not in mem_r yet.
        if (count_nxt_s == CW'(0)) begin
            head_nxt_s = T'(0);
        end else if (push && (wr_ptr_r == rd_ptr_nxt_s)) begin
            head_nxt_s = wdata;
        end else begin
            head_nxt_s = mem_r[rd_ptr_nxt_s];
        end
    end

    // Storage array; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointer, occupancy and registered status state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= CW'(0);
            head_r   <= T'(0);
            valid_r  <= 1'b0;
            full_r   <= 1'b0;
            empty_r  <= 1'b1;
        end else begin
            wr_ptr_r <= wr_ptr_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
            count_r  <= count_nxt_s;
            head_r   <= head_nxt_s;
            valid_r  <= (count_nxt_s != CW'(0));
            full_r   <= (count_nxt_s == CW'(DEPTH));
            empty_r  <= (count_nxt_s == CW'(0));
        end
    end

    assign head  = head_r;
    assign valid = valid_r;
    assign full  = full_r;
    assign empty = empty_r;
    assign count = count_r;

endmodule

// File: rtl/tri_bus_rx_chk.sv
// Protocol checker for the tri_bus_rx output stream.
module tri_bus_rx_chk #(
    parameter int W = 8
) (
    input logic         clk,
    input logic         rst,
    input logic         out_valid,
    input logic         out_ready,
    input logic [W-1:0] out_data
);
    // A stalled head word must not change under the consumer.
    property p_head_stable;
        @(posedge clk) disable iff (rst)
            (out_valid && !out_ready) |=> (out_data == $past(out_data));
    endproperty

    a_head_stable: assert property (p_head_stable);

endmodule

// File: rtl/tri_bus_rx.sv
// Listener endpoint of the shared tri-state bus: samples strobed words into a
// FIFO, presents them as a valid/ready stream and keeps sticky error flags.
module tri_bus_rx
    import tri_bus_pkg::*;
#(
    parameter type T     = bus_t,
    parameter int  DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  T                        bus,
    input  logic                    strb,
    output T                        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [fifo_aw(DEPTH):0] count,
    output logic                    float_err,
    output logic                    ovf_err,
    input  logic                    clr_err
);
    logic unknown_s;
    logic push_s;
    logic pop_s;
    logic drop_s;
    logic full_s;
    logic empty_s;
    err_t err_r;
    err_t err_nxt_s;

    // Accept/drop decision for the strobed word; a floating sample never enters the FIFO.
    always_comb begin
        unknown_s = strb & $isunknown(bus);
        pop_s     = ~empty_s & out_ready;
        push_s    = strb & ~unknown_s & (~full_s | pop_s);
        drop_s    = strb & ~unknown_s & full_s & ~pop_s;
    end

    // Sticky flags: a new error wins over a clear in the same cycle.
    always_comb begin
        err_nxt_s = err_r;
        if (unknown_s) begin
            err_nxt_s.float_err = 1'b1;
        end else if (clr_err) begin
            err_nxt_s.float_err = 1'b0;
        end else begin
            err_nxt_s.float_err = err_r.float_err;
        end

        if (drop_s) begin
            err_nxt_s.ovf_err = 1'b1;
        end else if (clr_err) begin
            err_nxt_s.ovf_err = 1'b0;
        end else begin
            err_nxt_s.ovf_err = err_r.ovf_err;
        end
    end

    // Error flag register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_r <= err_t'(2'b00);
        end else begin
            err_r <= err_nxt_s;
        end
    end

    tri_bus_fifo #(
        .T     (T),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .wdata (bus),
        .head  (out_data),
        .valid (out_valid),
        .full  (full_s),
        .empty (empty_s),
        .count (count)
    );

    assign float_err = err_r.float_err;
    assign ovf_err   = err_r.ovf_err;

endmodule

// File: tb/tb_tri_bus_rx.sv
// Self-checking bench for tri_bus_rx: directed vector table, hand-written
// corner sequences and a randomized run against a queue-based reference model.
module tb_tri_bus_rx;
    localparam int DEPTH = 4;

    logic       clk;
    logic       rst;
    logic       drv_en;
    logic [7:0] drv_word;
    logic       strb;
    logic       out_ready;
    logic       clr_err;
    wire  [7:0] bus_w;
    logic [7:0] out_data;
    logic       out_valid;
    logic [2:0] count;
    logic       float_err;
    logic       ovf_err;

    // Remote driver side of the shared net.
    assign bus_w = drv_en ? drv_word : 8'bzzzz_zzzz;

    tri_bus_rx #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus_w),
        .strb      (strb),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .float_err (float_err),
        .ovf_err   (ovf_err),
        .clr_err   (clr_err)
    );

    tri_bus_rx_chk #(.W(8)) u_chk (
        .clk       (clk),
        .rst       (rst),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [7:0] mq[$];
    logic [7:0] rx_q[$];
    logic       m_float = 1'b0;
    logic       m_ovf   = 1'b0;

    typedef struct {
        logic       s;
        logic       en;
        logic [7:0] w;
        logic       rdy;
        logic       clr;
        int         cnt;
        logic       v;
        logic [7:0] d;
        logic       ovf;
        string      tag;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic s, input logic en, input logic [7:0] w,
                                input logic rdy, input logic clr, input int cnt,
                                input logic v, input logic [7:0] d, input logic ovf,
                                input string tag);
        vec_t r;
        r.s = s; r.en = en; r.w = w; r.rdy = rdy; r.clr = clr;
        r.cnt = cnt; r.v = v; r.d = d; r.ovf = ovf; r.tag = tag;
        return r;
    endfunction

    // One clock: apply inputs, advance the reference model at mid-cycle, settle after the edge.
    task automatic cycle(input logic s, input logic en, input logic [7:0] w,
                         input logic rdy, input logic clr);
        logic m_pop, m_unk, m_push;
        strb = s; drv_en = en; drv_word = w; out_ready = rdy; clr_err = clr;
        @(negedge clk);
        m_pop  = (mq.size() != 0) && rdy;
        m_unk  = s && $isunknown(bus_w);
        m_push = s && !m_unk && ((mq.size() < DEPTH) || m_pop);
        if (out_valid && rdy) rx_q.push_back(out_data);
        if (m_pop) void'(mq.pop_front());
        if (m_push) mq.push_back(bus_w);
        if (m_unk) m_float = 1'b1;
        else if (clr) m_float = 1'b0;
        if (s && !m_unk && !m_push) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ":count"}, 32'(count), 32'(mq.size()));
        chk({tag, ":valid"}, 32'(out_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) chk({tag, ":data"}, 32'(out_data), 32'(mq[0]));
        chk({tag, ":float"}, 32'(float_err), 32'(m_float));
        chk({tag, ":ovf"}, 32'(ovf_err), 32'(m_ovf));
    endtask

    initial begin
        int sent;
        int guard;
        logic [2:0] cnt_before;

        rst = 1'b1; drv_en = 1'b0; drv_word = 8'h00; strb = 1'b0;
        out_ready = 1'b0; clr_err = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("reset:count", 32'(count), 32'd0);
        chk("reset:valid", 32'(out_valid), 32'd0);
        chk("reset:data", 32'(out_data), 32'd0);
        chk("reset:float", 32'(float_err), 32'd0);
        chk("reset:ovf", 32'(ovf_err), 32'd0);

        // Directed table: single word, fill/overflow, full with pop, flag set/clear priority.
        tbl.push_back(mk(1'b1, 1'b1, 8'h05, 1'b0, 1'b0, 1, 1'b1, 8'h05, 1'b0, "single_push"));
        tbl.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 8'h00, 1'b0, "single_pop"));
        for (int i = 1; i <= 4; i++)
            tbl.push_back(mk(1'b1, 1'b1, 8'(i), 1'b0, 1'b0, i, 1'b1, 8'h01, 1'b0, "fill"));
        tbl.push_back(mk(1'b1, 1'b1, 8'h05, 1'b0, 1'b0, 4, 1'b1, 8'h01, 1'b1, "overflow"));
        for (int i = 2; i <= 4; i++)
            tbl.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 5 - i, 1'b1, 8'(i), 1'b1, "drain"));
        tbl.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 8'h00, 1'b1, "drain_last"));
        tbl.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0, 8'h00, 1'b0, "clr_ovf"));
        for (int i = 1; i <= 4; i++)
            tbl.push_back(mk(1'b1, 1'b1, 8'(i), 1'b0, 1'b0, i, 1'b1, 8'h01, 1'b0, "fill2"));
        tbl.push_back(mk(1'b1, 1'b1, 8'h09, 1'b1, 1'b0, 4, 1'b1, 8'h02, 1'b0, "full_push_pop"));
        tbl.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 3, 1'b1, 8'h03, 1'b0, "drain2"));
        tbl.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 2, 1'b1, 8'h04, 1'b0, "drain2"));
        tbl.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b1, 8'h09, 1'b0, "drain2"));
        tbl.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 8'h00, 1'b0, "drain2_last"));
        for (int i = 1; i <= 4; i++)
            tbl.push_back(mk(1'b1, 1'b1, 8'(i), 1'b0, 1'b0, i, 1'b1, 8'h01, 1'b0, "fill3"));
        tbl.push_back(mk(1'b1, 1'b1, 8'h07, 1'b0, 1'b1, 4, 1'b1, 8'h01, 1'b1, "set_beats_clr"));
        tbl.push_back(mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 4, 1'b1, 8'h01, 1'b0, "clr_alone"));
        for (int i = 2; i <= 4; i++)
            tbl.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 5 - i, 1'b1, 8'(i), 1'b0, "drain3"));
        tbl.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 8'h00, 1'b0, "drain3_last"));

        foreach (tbl[k]) begin
            cycle(tbl[k].s, tbl[k].en, tbl[k].w, tbl[k].rdy, tbl[k].clr);
            chk({tbl[k].tag, ":count"}, 32'(count), 32'(tbl[k].cnt));
            chk({tbl[k].tag, ":valid"}, 32'(out_valid), 32'(tbl[k].v));
            if (tbl[k].v) chk({tbl[k].tag, ":data"}, 32'(out_data), 32'(tbl[k].d));
            chk({tbl[k].tag, ":ovf"}, 32'(ovf_err), 32'(tbl[k].ovf));
            chk({tbl[k].tag, ":float"}, 32'(float_err), 32'd0);
        end

        // Floating bus: ignored without strobe, flagged with strobe, set beats clear.
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        check_model("float_nostrb");
        chk("float_nostrb:flag", 32'(float_err), 32'd0);
        cnt_before = count;
        cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        check_model("float_strb");
        if (m_float) chk("float_strb:count_hold", 32'(count), 32'(cnt_before));
        cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        check_model("float_set_clr");
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        check_model("float_clr");
        chk("float_clr:flag", 32'(float_err), 32'd0);
        guard = 0;
        while (mq.size() != 0 && guard < 10) begin
            cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
            guard++;
        end

        // Asynchronous reset mid-cycle while holding two words and a raised flag.
        for (int i = 1; i <= 5; i++) cycle(1'b1, 1'b1, 8'(i), 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("pre_reset:count", 32'(count), 32'd2);
        chk("pre_reset:ovf", 32'(ovf_err), 32'd1);
        strb = 1'b0; drv_en = 1'b0; out_ready = 1'b0; clr_err = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset:count", 32'(count), 32'd0);
        chk("async_reset:valid", 32'(out_valid), 32'd0);
        chk("async_reset:data", 32'(out_data), 32'd0);
        chk("async_reset:float", 32'(float_err), 32'd0);
        chk("async_reset:ovf", 32'(ovf_err), 32'd0);
        mq.delete();
        m_float = 1'b0;
        m_ovf   = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Wrap-around stream of 20 words with a toggling consumer; source honours backpressure.
        rx_q.delete();
        sent  = 0;
        guard = 0;
        while (rx_q.size() < 20 && guard < 200) begin
            if (sent < 20 && mq.size() < DEPTH) begin
                cycle(1'b1, 1'b1, 8'(sent), guard[0] == 1'b0, 1'b0);
                sent++;
            end else begin
                cycle(1'b0, 1'b0, 8'h00, guard[0] == 1'b0, 1'b0);
            end
            check_model("wrap");
            guard++;
        end
        chk("wrap:received", 32'(rx_q.size()), 32'd20);
        foreach (rx_q[k]) chk("wrap:order", 32'(rx_q[k]), 32'(k));
        chk("wrap:float", 32'(float_err), 32'd0);
        chk("wrap:ovf", 32'(ovf_err), 32'd0);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 400; n++) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 15) != 0, 8'($urandom),
                  1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0);
            check_model("random");
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
